// File: rtl/fir_axil_pkg.sv
// fir_axil_pkg: AXI response codes, write/read FSM states and the status-word offset helper.
package fir_axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  function automatic int status_offset(input int num_rw_regs);
    return num_rw_regs;
  endfunction
endpackage

// File: rtl/fir_axil_wstrb_merge.sv
// fir_axil_wstrb_merge: byte-lane merge; old_data/wdata/wstrb in, merged out.
module fir_axil_wstrb_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] merged
);
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign merged[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old_data[b*8 +: 8];
  end
endmodule

// File: rtl/fir_axil_regfile.sv
// fir_axil_regfile: AXI4-Lite register bank for the FIR core.
// Ports: ACLK/ARESET; AXI4-Lite AW/W/B/AR/R channels; reg_out (RW register
// contents), wr_pulse (one-cycle per-register write strobe), status_in (RO word).
module fir_axil_regfile
  import fir_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_RW_REGS        = 4
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         AWADDR,
  input  logic [2:0]                            AWPROT,
  input  logic                                  AWVALID,
  output logic                                  AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]         WDATA,
  input  logic [3:0]                            WSTRB,
  input  logic                                  WVALID,
  output logic                                  WREADY,
  output logic [1:0]                            BRESP,
  output logic                                  BVALID,
  input  logic                                  BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         ARADDR,
  input  logic [2:0]                            ARPROT,
  input  logic                                  ARVALID,
  output logic                                  ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]         RDATA,
  output logic [1:0]                            RRESP,
  output logic                                  RVALID,
  input  logic                                  RREADY,
  output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_RW_REGS-1:0]                wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]         status_in
);
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [IW-1:0] NRW  = IW'(NUM_RW_REGS);
  localparam logic [IW-1:0] STAT = IW'(status_offset(NUM_RW_REGS));
  wstate_t ws_q, ws_d;
  rstate_t rs_q, rs_d;
  logic have_aw_q, have_aw_d, have_w_q, have_w_d;
  logic [IW-1:0] aw_idx_q, aw_idx_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [NUM_RW_REGS*DW-1:0] regs_q, regs_d;
  logic [NUM_RW_REGS-1:0] pulse_q, pulse_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic aw_hs, w_hs, ar_hs, commit, c_rw;
  logic [IW-1:0] c_idx, ar_idx;
  logic [DW-1:0] c_data, old_word, new_word, rd_word;
  logic [3:0] c_strb;
  logic unused_bits;
  assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};
  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  // A half that is not latched yet is taken straight from the bus, so both
  // orders and the same-cycle case all commit on the later handshake edge.
  assign c_idx  = have_aw_q ? aw_idx_q : AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign c_data = have_w_q ? wdata_q : WDATA;
  assign c_strb = have_w_q ? wstrb_q : WSTRB;
  assign commit = (have_aw_q || aw_hs) && (have_w_q || w_hs);
  assign c_rw   = c_idx < NRW;
  assign ar_idx = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  fir_axil_wstrb_merge u_merge (
    .old_data(old_word),
    .wdata   (c_data),
    .wstrb   (c_strb),
    .merged  (new_word)
  );
  always_comb begin
    old_word = '0;
    rd_word  = '0;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      old_word = c_idx == IW'(i) ? regs_q[i*DW +: DW] : old_word;
      rd_word  = ar_idx == IW'(i) ? regs_q[i*DW +: DW] : rd_word;
    end
  end
  always_comb begin
    ws_d      = ws_q == W_IDLE ? (commit ? W_RESP : W_IDLE) : (BREADY ? W_IDLE : W_RESP);
    rs_d      = rs_q == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (RREADY ? R_IDLE : R_DATA);
    have_aw_d = !commit && (have_aw_q || aw_hs);
    have_w_d  = !commit && (have_w_q || w_hs);
    aw_idx_d  = aw_hs ? AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
    wdata_d   = w_hs ? WDATA : wdata_q;
    wstrb_d   = w_hs ? WSTRB : wstrb_q;
    bresp_d   = commit ? (c_rw ? RESP_OKAY : RESP_SLVERR) : bresp_q;
    // Read data comes from regs_q, so a same-edge write is not visible yet.
    rdata_d   = ar_hs ? (ar_idx < NRW ? rd_word : (ar_idx == STAT ? status_in : '0)) : rdata_q;
    rresp_d   = ar_hs ? (ar_idx <= STAT ? RESP_OKAY : RESP_SLVERR) : rresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      pulse_d[i] = commit && c_idx == IW'(i);
      regs_d[i*DW +: DW] = pulse_d[i] ? new_word : regs_q[i*DW +: DW];
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ws_q      <= W_IDLE;
      rs_q      <= R_IDLE;
      have_aw_q <= 1'b0;
      have_w_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      regs_q    <= '0;
      pulse_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      ws_q      <= ws_d;
      rs_q      <= rs_d;
      have_aw_q <= have_aw_d;
      have_w_q  <= have_w_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end
  always_comb begin
    AWREADY = !ARESET && ws_q == W_IDLE && !have_aw_q;
    WREADY  = !ARESET && ws_q == W_IDLE && !have_w_q;
    ARREADY = !ARESET && rs_q == R_IDLE;
    BVALID  = ws_q == W_RESP;
    RVALID  = rs_q == R_DATA;
  end
  assign BRESP    = bresp_q;
  assign RRESP    = rresp_q;
  assign RDATA    = rdata_q;
  assign reg_out  = regs_q;
  assign wr_pulse = pulse_q;
endmodule

// File: tb/tb_fir_axil_regfile.sv
// tb_fir_axil_regfile: table-driven and scoreboarded check of fir_axil_regfile.
module tb_fir_axil_regfile;
  import fir_axil_pkg::*;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [5:0] AWADDR = '0, ARADDR = '0;
  logic [2:0] AWPROT = '0, ARPROT = '0;
  logic AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b1, ARVALID = 1'b0, RREADY = 1'b1;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [31:0] WDATA = '0, RDATA, status_in = 32'hA5A5A5A5;
  logic [3:0] WSTRB = '0, wr_pulse;
  logic [1:0] BRESP, RRESP;
  logic [127:0] reg_out, mreg = '0;
  int total = 0, bad = 0;
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t tbl[19];

  fir_axil_regfile dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .status_in(status_in)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_wr(input int k, input logic [31:0] d, input logic [3:0] s);
    if (k < 4)
      for (int b = 0; b < 4; b++)
        if (s[b]) mreg[k*32 + b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
    int k, n;
    logic ah, wh;
    logic [3:0] ep;
    k = int'(a[5:2]);
    ep = k < 4 ? 4'b0001 << k : 4'b0000;
    bq.push_back(er);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; n = 0;
    while ((AWVALID || WVALID) && n < 20) begin
      ah = AWVALID && AWREADY;
      wh = WVALID && WREADY;
      tick;
      if (ah) AWVALID = 1'b0;
      if (wh) WVALID = 1'b0;
      n++;
    end
    if (AWVALID || WVALID) begin
      total++; bad++;
      $display("FAIL wr_handshake_timeout actual=pending required=done");
      AWVALID = 1'b0; WVALID = 1'b0;
    end
    model_wr(k, d, s);
    chk("wr_bvalid", 128'(BVALID), 128'(1));
    chk("wr_bresp", 128'(BRESP), 128'(bq.pop_front()));
    chk("wr_reg_out", reg_out, mreg);
    chk("wr_pulse", 128'(wr_pulse), 128'(ep));
    tick;
    chk("wr_pulse_clear", 128'(wr_pulse), 128'(0));
    chk("wr_bvalid_clear", 128'(BVALID), 128'(0));
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er);
    int n;
    logic hs;
    logic [33:0] e;
    rq.push_back({ed, er});
    ARADDR = a; ARVALID = 1'b1; n = 0; hs = 1'b0;
    while (!hs && n < 20) begin
      hs = ARREADY;
      tick;
      n++;
    end
    ARVALID = 1'b0;
    if (!hs) begin
      total++; bad++;
      $display("FAIL rd_handshake_timeout actual=pending required=done");
    end
    e = rq.pop_front();
    chk("rd_rvalid", 128'(RVALID), 128'(1));
    chk("rd_rdata", 128'(RDATA), 128'(e[33:2]));
    chk("rd_rresp", 128'(RRESP), 128'(e[1:0]));
    tick;
    chk("rd_rvalid_clear", 128'(RVALID), 128'(0));
  endtask

  task automatic skew(input logic aw_first, input logic [31:0] d);
    bq.push_back(RESP_OKAY);
    AWADDR = 6'h04; WDATA = d; WSTRB = 4'hF;
    if (aw_first) AWVALID = 1'b1; else WVALID = 1'b1;
    tick;
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("skew_awready", 128'(AWREADY), 128'(!aw_first));
    chk("skew_wready", 128'(WREADY), 128'(aw_first));
    repeat (2) begin
      tick;
      chk("skew_no_early_b", 128'(BVALID), 128'(0));
    end
    if (aw_first) WVALID = 1'b1; else AWVALID = 1'b1;
    tick;
    AWVALID = 1'b0; WVALID = 1'b0;
    mreg[63:32] = d;
    chk("skew_bvalid", 128'(BVALID), 128'(1));
    chk("skew_bresp", 128'(BRESP), 128'(bq.pop_front()));
    chk("skew_reg1", 128'(reg_out[63:32]), 128'(d));
    chk("skew_pulse", 128'(wr_pulse), 128'(4'b0010));
    tick;
    chk("skew_single_commit", 128'(BVALID), 128'(0));
    chk("skew_pulse_clear", 128'(wr_pulse), 128'(0));
  endtask

  initial begin
    logic [1:0] eb;
    logic [33:0] e;
    tbl[0]  = '{1'b1, 6'h00, 32'h1,        4'hF, 32'h0,        RESP_OKAY};
    tbl[1]  = '{1'b1, 6'h04, 32'h2,        4'hF, 32'h0,        RESP_OKAY};
    tbl[2]  = '{1'b1, 6'h08, 32'h3,        4'hF, 32'h0,        RESP_OKAY};
    tbl[3]  = '{1'b1, 6'h0C, 32'h4,        4'hF, 32'h0,        RESP_OKAY};
    tbl[4]  = '{1'b0, 6'h00, 32'h0,        4'h0, 32'h1,        RESP_OKAY};
    tbl[5]  = '{1'b0, 6'h04, 32'h0,        4'h0, 32'h2,        RESP_OKAY};
    tbl[6]  = '{1'b0, 6'h08, 32'h0,        4'h0, 32'h3,        RESP_OKAY};
    tbl[7]  = '{1'b0, 6'h0C, 32'h0,        4'h0, 32'h4,        RESP_OKAY};
    tbl[8]  = '{1'b0, 6'h10, 32'h0,        4'h0, 32'hA5A5A5A5, RESP_OKAY};
    tbl[9]  = '{1'b1, 6'h10, 32'h11111111, 4'hF, 32'h0,        RESP_SLVERR};
    tbl[10] = '{1'b0, 6'h10, 32'h0,        4'h0, 32'hA5A5A5A5, RESP_OKAY};
    tbl[11] = '{1'b0, 6'h3C, 32'h0,        4'h0, 32'h0,        RESP_SLVERR};
    tbl[12] = '{1'b1, 6'h3C, 32'h22222222, 4'hF, 32'h0,        RESP_SLVERR};
    tbl[13] = '{1'b1, 6'h00, 32'hFFFFFFFF, 4'hF, 32'h0,        RESP_OKAY};
    tbl[14] = '{1'b1, 6'h00, 32'h12345678, 4'h5, 32'h0,        RESP_OKAY};
    tbl[15] = '{1'b0, 6'h00, 32'h0,        4'h0, 32'hFF34FF78, RESP_OKAY};
    tbl[16] = '{1'b1, 6'h04, 32'h99999999, 4'h0, 32'h0,        RESP_OKAY};
    tbl[17] = '{1'b0, 6'h05, 32'h0,        4'h0, 32'h2,        RESP_OKAY};
    tbl[18] = '{1'b0, 6'h2B, 32'h0,        4'h0, 32'h0,        RESP_SLVERR};

    repeat (2) tick;
    chk("rst_awready", 128'(AWREADY), 128'(0));
    chk("rst_wready", 128'(WREADY), 128'(0));
    chk("rst_arready", 128'(ARREADY), 128'(0));
    chk("rst_bvalid", 128'(BVALID), 128'(0));
    ARESET = 1'b0;
    tick;
    chk("post_rst_awready", 128'(AWREADY), 128'(1));
    chk("post_rst_wready", 128'(WREADY), 128'(1));
    chk("post_rst_arready", 128'(ARREADY), 128'(1));
    chk("post_rst_rvalid", 128'(RVALID), 128'(0));
    chk("post_rst_rdata", 128'(RDATA), 128'(0));
    chk("post_rst_resp", 128'({BRESP, RRESP}), 128'(0));
    chk("post_rst_reg_out", reg_out, 128'(0));
    chk("post_rst_pulse", 128'(wr_pulse), 128'(0));

    for (int i = 0; i < 19; i++)
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp_resp);
      else rd(tbl[i].addr, tbl[i].exp_data, tbl[i].exp_resp);

    skew(1'b0, 32'hDEADBEEF);
    skew(1'b1, 32'hCAFEF00D);

    BREADY = 1'b0; RREADY = 1'b0;
    bq.push_back(RESP_OKAY);
    rq.push_back({32'h3, RESP_OKAY});
    AWADDR = 6'h08; WDATA = 32'h55; WSTRB = 4'hF; ARADDR = 6'h08;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    mreg[95:64] = 32'h55;
    eb = bq.pop_front();
    e = rq.pop_front();
    chk("bp_reg_out", reg_out, mreg);
    chk("bp_pulse", 128'(wr_pulse), 128'(4'b0100));
    for (int i = 0; i < 10; i++) begin
      chk("bp_bvalid", 128'(BVALID), 128'(1));
      chk("bp_bresp", 128'(BRESP), 128'(eb));
      chk("bp_rvalid", 128'(RVALID), 128'(1));
      chk("bp_rdata_prewrite", 128'(RDATA), 128'(e[33:2]));
      chk("bp_rresp", 128'(RRESP), 128'(e[1:0]));
      chk("bp_ready_low", 128'({AWREADY, WREADY, ARREADY}), 128'(0));
      tick;
    end
    BREADY = 1'b1;
    tick;
    chk("bp_b_released", 128'(BVALID), 128'(0));
    chk("bp_awready_back", 128'(AWREADY), 128'(1));
    chk("bp_r_still_held", 128'(RVALID), 128'(1));
    chk("bp_arready_still_low", 128'(ARREADY), 128'(0));
    RREADY = 1'b1;
    tick;
    chk("bp_r_released", 128'(RVALID), 128'(0));
    chk("bp_arready_back", 128'(ARREADY), 128'(1));
    rd(6'h08, 32'h55, RESP_OKAY);

    BREADY = 1'b0;
    AWADDR = 6'h0C; WDATA = 32'h77; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick;
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("midrst_bvalid_pending", 128'(BVALID), 128'(1));
    ARESET = 1'b1;
    tick;
    mreg = '0;
    chk("midrst_bvalid", 128'(BVALID), 128'(0));
    chk("midrst_ready", 128'({AWREADY, WREADY, ARREADY}), 128'(0));
    chk("midrst_rvalid", 128'(RVALID), 128'(0));
    chk("midrst_rdata", 128'(RDATA), 128'(0));
    chk("midrst_resp", 128'({BRESP, RRESP}), 128'(0));
    chk("midrst_reg_out", reg_out, 128'(0));
    chk("midrst_pulse", 128'(wr_pulse), 128'(0));
    ARESET = 1'b0; BREADY = 1'b1;
    repeat (3) begin
      tick;
      chk("midrst_no_stale_b", 128'(BVALID), 128'(0));
    end
    chk("midrst_awready", 128'(AWREADY), 128'(1));
    rd(6'h0C, 32'h0, RESP_OKAY);
    wr(6'h0C, 32'h77, 4'hF, RESP_OKAY);
    rd(6'h0C, 32'h77, RESP_OKAY);
    rd(6'h00, 32'h0, RESP_OKAY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_axil_regfile.md
# fir_axil_regfile

AXI4-Lite responder that terminates master-side register traffic for the FIR block. It holds a small bank of read/write control registers and one read-only status word, exposes the registers to the FIR datapath, and pulses a per-register write strobe. It sits between the AXI interconnect (or VIP master in simulation) and the FIR core.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6: byte address width, giving 16 word slots.
- NUM_RW_REGS, 4: number of read/write registers at word offsets 0..NUM_RW_REGS-1; legal range 1..15.

- ACLK  in  1  sole clock; all logic on its rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- AWPROT  in  3  ignored.
- AWVALID / AWREADY  in / out  1  write address handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables.
- WVALID / WREADY  in / out  1  write data handshake.
- BRESP  out  2  write response.
- BVALID / BREADY  out / in  1  write response handshake.
- ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- ARPROT  in  3  ignored.
- ARVALID / ARREADY  in / out  1  read address handshake.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID / RREADY  out / in  1  read data handshake.
- reg_out  out  NUM_RW_REGS*32  current register contents; register i occupies bits [32i+31:32i].
- wr_pulse  out  NUM_RW_REGS  one-cycle strobe, asserted when register i is written.
- status_in  in  32  read-only status, mapped at word offset NUM_RW_REGS.

## Operation
- Decode uses word index = addr[C_S_AXI_ADDR_WIDTH-1:2]. Bits [1:0] are ignored.
  - Index < NUM_RW_REGS: read/write register.
  - Index == NUM_RW_REGS: status_in, read-only. Writes return SLVERR and have no effect.
  - Higher indices: unmapped. Writes return SLVERR. Reads return 0 with SLVERR.
- Write channel FSM:
  - States: W_IDLE and W_RESP.
  - In W_IDLE, AW and W are accepted independently, in any order or in the same cycle. Each is latched into a holding register with its own "have" flag.
  - AWREADY = W_IDLE && !have_aw. WREADY = W_IDLE && !have_w.
  - Commit happens on the edge where both are present, counting flags plus the current handshake. That edge:
    - updates bytes selected by WSTRB;
    - sets wr_pulse[i] for the next cycle (only for mapped RW targets);
    - clears both flags;
    - sets BVALID with BRESP = OKAY (00) or SLVERR (10);
    - enters W_RESP.
  - W_RESP holds BVALID/BRESP stable until BVALID && BREADY, then returns to W_IDLE.
  - Commit with WSTRB = 0 returns OKAY, changes no data, and still pulses wr_pulse.
- Read channel FSM:
  - States: R_IDLE and R_DATA.
  - ARREADY = R_IDLE.
  - On the AR handshake, RDATA/RRESP are registered from the decode and RVALID is set; enter R_DATA.
  - Hold stable until RVALID && RREADY, then return to R_IDLE.
- Read and write channels are fully independent.
- Same-edge read handshake and write commit to the same register: the read returns the pre-write value.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY = 0 during reset, 1 from the first cycle after reset.
  - BVALID = 0, RVALID = 0, BRESP = 00, RRESP = 00, RDATA = 0, wr_pulse = 0.
  - reg_out = 0; both FSMs idle; holding flags cleared.
- Write latency: BVALID and the updated reg_out are visible 1 cycle after the completing handshake edge. wr_pulse is high for exactly that cycle.
- Read latency: RVALID is visible 1 cycle after the AR handshake edge.
- Back-to-back throughput: one write per 2 cycles with BREADY tied high; one read per 2 cycles with RREADY tied high.
- Back-pressure: BREADY or RREADY held low stalls the respective channel indefinitely, with outputs stable. The other channel keeps running.
- Reset mid-transaction discards latched AW/W, pending responses and register contents. No response is issued for transactions that were in flight.

## Structure
- Shared package fir_axil_pkg holds:
  - AXI response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - the write and read FSM state enums;
  - the status word offset helper.
- One sub-module, fir_axil_wstrb_merge: combinational byte-lane merge of old data, WDATA and WSTRB.
- Everything else lives in one module.

## Test plan
- Sequential fill: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four back. Required: data 1, 2, 3, 4, every BRESP/RRESP = OKAY, wr_pulse[i] seen exactly once each.
- Order skew: W presented 3 cycles before AW (and the reverse) to 0x4 with 0xDEADBEEF. Required: a single commit, reg_out[63:32] = 0xDEADBEEF, BVALID one cycle after the later handshake.
- Byte strobes: reg0 = 0xFFFFFFFF, then write 0x12345678 with WSTRB = 0101. Required: reads back 0xFF34FF78.
- Decode: read offset 0x10 with status_in = 0xA5A5A5A5, write 0x10, read 0x3C. Required:
  - 0x10 read: 0xA5A5A5A5 / OKAY;
  - 0x10 write: SLVERR, and the next read of 0x10 still returns 0xA5A5A5A5;
  - 0x3C read: 0 / SLVERR.
- Back-pressure: BREADY and RREADY held low for 10 cycles. Required: BVALID/RVALID stable with unchanged data, AWREADY/WREADY/ARREADY low until the response is accepted.
- Reset mid-op: ARESET asserted while BVALID is pending. Required: all outputs at reset values the next cycle, reg_out = 0, and no stale BVALID after release.
